wb_dbg_master: RTL and testbench
================================

Name: wb_dbg_master

Overview:
- Wishbone initiator (master) driven by a byte-stream command protocol. Lets a host read and write any slave on the interconnect over a serial link without the CPU.
- Occupies a free master port on the Wishbone interconnect, alongside the LM32 instruction and data masters.
- Byte stream comes from / goes to an existing UART core's rx/tx strobes; no UART PHY inside this block.

Parameters:
- TIMEOUT_W, 16: width of the bus-cycle watchdog; a cycle aborts after 2^TIMEOUT_W-1 clocks without ack/err.
- RX_IDLE_MAX, 5000000: inter-byte timeout in clocks (used only with the optional feature).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-low
- rx_data_i  in  8  received byte
- rx_stb_i  in  1  one-cycle strobe, rx_data_i valid
- tx_data_o  out  8  byte to transmit
- tx_stb_o  out  1  one-cycle strobe, tx_data_o valid
- tx_busy_i  in  1  transmitter busy; tx_stb_o only when low
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte select, always 4'hF during a cycle
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error
- wb_rty_i  in  1  retry
- busy_o  out  1  high whenever state != IDLE
- ovr_o  out  1  one-cycle pulse when an rx byte is dropped

Behaviour:
- Reset (rst_i==0 at a clk_i edge): state IDLE. All outputs 0, including wb_adr_o, wb_dat_o, wb_sel_o and tx_data_o. Counters cleared. Reset mid-cycle drops cyc/stb on the next edge, with no response byte.
- Commands: 0x57 'W' + 4 address bytes + 4 data bytes (MSB first) performs a write. 0x52 'R' + 4 address bytes performs a read. Any other byte in IDLE is ignored.
- States:
  - IDLE: on rx_stb_i with 'W' or 'R', latch the opcode and go to ADDR.
  - ADDR: shift 4 bytes into wb_adr_o (adr <= {adr[23:0], byte}). After the 4th byte go to DATA if 'W', else BUS.
  - DATA: shift 4 bytes into wb_dat_o the same way, then go to BUS.
  - BUS: assert cyc/stb/sel=F; we=1 for 'W'.
    - ack: cyc/stb low on the next edge, latch wb_dat_i for 'R', status=OK (0x4B).
    - err: release, status=ERR (0x45).
    - rty: release for exactly 1 cycle, then reassert. The watchdog is not reset on retry.
    - Watchdog saturates: release, status=ERR.
    - Simultaneous ack+err: err wins.
  - RESP: wait for tx_busy_i==0, then pulse tx_stb_o with the status byte.
    - 'W', or any ERR: go to IDLE.
    - 'R' with OK: go to SEND.
  - SEND: emit 4 read-data bytes MSB first, each after tx_busy_i==0. Exactly one tx_stb_o per byte, never two on consecutive cycles. Then go to IDLE.
- Latency: cyc/stb rises on the clock edge after the last command byte. Status strobe is no earlier than 1 cycle after cyc drops.
- rx_stb_i in BUS/RESP/SEND: byte dropped, ovr_o pulses, state unchanged.
- Watchdog counter is TIMEOUT_W bits, cleared on entry to BUS, and never wraps.
- Address and data registers hold their last value after a transaction.

Optional Feature:
- WB_DBG_RX_TIMEOUT_EN:
  - Defined: in ADDR/DATA, an idle counter is cleared on every rx_stb_i. Reaching RX_IDLE_MAX returns to IDLE silently and discards the partial command.
  - Undefined: ADDR/DATA wait indefinitely, and no idle counter is synthesised.

Decomposition:
- Package wb_dbg_pkg: opcode constants CMD_WR=8'h57, CMD_RD=8'h52; status constants ST_OK=8'h4B, ST_ERR=8'h45; state enum IDLE/ADDR/DATA/BUS/RESP/SEND.
- No sub-module required. The byte-shift/emit counter stays inline.

Test Plan:
- Write: rx 57 00 00 F0 00 00 00 00 41, slave acks after 2 cycles -> wb cycle adr=0000F000, dat=00000041, we=1, sel=F; tx 4B.
- Read: rx 52 00 00 00 10, slave returns DEADBEEF with ack -> tx 4B DE AD BE EF. tx_busy_i held high 10 cycles per byte; strobes never overlap busy.
- Error: read with wb_err_i on the 1st cycle -> cyc drops next edge, tx 45 only. Repeat with ack+err together -> 45.
- Timeout: TIMEOUT_W=4, no response -> cyc released after 15 cycles, tx 45. rty pulsed twice -> 1-cycle gaps, same total timeout.
- Overrun and reset: extra byte during BUS -> ovr_o pulse, response unchanged. Reset asserted mid-BUS -> cyc=0 next edge, no tx, next 'R' command works.
- Feature (WB_DBG_RX_TIMEOUT_EN, RX_IDLE_MAX=100): 57 00 then 150 idle cycles, then 52 00 00 00 10 -> only the read executes.

Source files
------------

// File: rtl/wb_dbg_pkg.sv
// Shared constants and state encoding for the byte-stream driven Wishbone debug master.
package wb_dbg_pkg;

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ST_OK  = 8'h4B;
    localparam logic [7:0] ST_ERR = 8'h45;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StBus,
        StResp,
        StSend
    } state_e;

endpackage

// File: rtl/wb_dbg_master.sv
// Wishbone initiator fed by a UART byte stream: 'W' adr[4] dat[4] writes, 'R' adr[4] reads.
// Optional WB_DBG_RX_TIMEOUT_EN drops a partial command after RX_IDLE_MAX idle clocks.
module wb_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_W   = 16,
    parameter int unsigned RX_IDLE_MAX = 5000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_stb_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_stb_o,
    input  logic        tx_busy_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        busy_o,
    output logic        ovr_o
);

    if (TIMEOUT_W < 2 || RX_IDLE_MAX == 0) begin : g_bad_param
        $error("wb_dbg_master: TIMEOUT_W must be >= 2 and RX_IDLE_MAX nonzero");
    end

    // Abort on the edge where the watchdog would reach all-ones: 2^W-1 bus clocks in total.
    localparam logic [TIMEOUT_W-1:0] WdogLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_e               state_q, state_d;
    logic                 is_wr_q, is_wr_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic [31:0]          rdat_q, rdat_d;
    logic [7:0]           status_q, status_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 gap_q, gap_d;
    logic                 tx_stb_q, tx_stb_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 ovr_q, ovr_d;
    logic                 tx_fire;

`ifdef WB_DBG_RX_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(RX_IDLE_MAX + 1);
    logic [IdleW-1:0] idle_q, idle_d;

    always_ff @(posedge clk_i) begin
        if (!rst_i) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            is_wr_q   <= 1'b0;
            cnt_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rdat_q    <= '0;
            status_q  <= '0;
            wdog_q    <= '0;
            gap_q     <= 1'b0;
            tx_stb_q  <= 1'b0;
            tx_data_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            is_wr_q   <= is_wr_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rdat_q    <= rdat_d;
            status_q  <= status_d;
            wdog_q    <= wdog_d;
            gap_q     <= gap_d;
            tx_stb_q  <= tx_stb_d;
            tx_data_q <= tx_data_d;
            ovr_q     <= ovr_d;
        end
    end

    // Never strobe twice in a row, even if the transmitter raises busy late.
    assign tx_fire = !tx_busy_i && !tx_stb_q;

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rdat_d    = rdat_q;
        status_d  = status_q;
        wdog_d    = wdog_q;
        gap_d     = gap_q;
        tx_stb_d  = 1'b0;
        tx_data_d = tx_data_q;
        ovr_d     = rx_stb_i && (state_q inside {StBus, StResp, StSend});
        unique case (state_q)
            StIdle: begin
                if (rx_stb_i && (rx_data_i == CMD_WR || rx_data_i == CMD_RD)) begin
                    is_wr_d = (rx_data_i == CMD_WR);
                    cnt_d   = '0;
                    state_d = StAddr;
                end
            end
            StAddr, StData: begin
                if (rx_stb_i) begin
                    if (state_q == StAddr) adr_d = {adr_q[23:0], rx_data_i};
                    else                   dat_d = {dat_q[23:0], rx_data_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = (state_q == StAddr && is_wr_q) ? StData : StBus;
                        wdog_d  = '0;
                        gap_d   = 1'b0;
                    end
                end
            end
            StBus: begin
                wdog_d = wdog_q + 1'b1;
                gap_d  = 1'b0;
                if (!gap_q && wb_err_i) begin
                    status_d = ST_ERR;
                    state_d  = StResp;
                end else if (!gap_q && wb_ack_i) begin
                    status_d = ST_OK;
                    if (!is_wr_q) rdat_d = wb_dat_i;
                    state_d  = StResp;
                end else if (wdog_q == WdogLast) begin
                    status_d = ST_ERR;
                    state_d  = StResp;
                end else if (!gap_q && wb_rty_i) begin
                    gap_d = 1'b1;
                end
            end
            StResp: begin
                if (tx_fire) begin
                    tx_stb_d  = 1'b1;
                    tx_data_d = status_q;
                    cnt_d     = '0;
                    state_d   = (is_wr_q || status_q != ST_OK) ? StIdle : StSend;
                end
            end
            StSend: begin
                if (tx_fire) begin
                    tx_stb_d  = 1'b1;
                    tx_data_d = rdat_q[31:24];
                    rdat_d    = {rdat_q[23:0], 8'h00};
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef WB_DBG_RX_TIMEOUT_EN
        idle_d = '0;
        if ((state_q == StAddr || state_q == StData) && !rx_stb_i) begin
            idle_d = idle_q + 1'b1;
            if (idle_q == IdleW'(RX_IDLE_MAX - 1)) begin
                idle_d  = '0;
                state_d = StIdle;
            end
        end
`endif
    end

    always_comb begin
        wb_cyc_o  = (state_q == StBus) && !gap_q;
        wb_stb_o  = wb_cyc_o;
        wb_sel_o  = wb_cyc_o ? 4'hF : 4'h0;
        wb_we_o   = wb_cyc_o && is_wr_q;
        wb_adr_o  = adr_q;
        wb_dat_o  = dat_q;
        tx_stb_o  = tx_stb_q;
        tx_data_o = tx_data_q;
        busy_o    = (state_q != StIdle);
        ovr_o     = ovr_q;
    end

endmodule

// File: tb/tb_wb_dbg_master.sv
// Directed bench for wb_dbg_master: write, read, error, timeout, retry, overrun, reset.
// Exercises WB_DBG_RX_TIMEOUT_EN behaviour when the macro is defined.
module tb_wb_dbg_master;
    import wb_dbg_pkg::*;

    localparam int unsigned TW      = 4;
    localparam int unsigned IdleMax = 100;

    typedef enum int {SlvAck, SlvErr, SlvAckErr, SlvNone, SlvRty} slv_mode_e;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_stb_i = 1'b0;
    logic [7:0]  tx_data_o;
    logic        tx_stb_o;
    logic        tx_busy_i = 1'b0;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
    logic        busy_o, ovr_o;

    wb_dbg_master #(
        .TIMEOUT_W  (TW),
        .RX_IDLE_MAX(IdleMax)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .rx_data_i(rx_data_i),
        .rx_stb_i (rx_stb_i),
        .tx_data_o(tx_data_o),
        .tx_stb_o (tx_stb_o),
        .tx_busy_i(tx_busy_i),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i),
        .busy_o   (busy_o),
        .ovr_o    (ovr_o)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    slv_mode_e   slv_mode = SlvAck;
    int          ack_wait = 0;
    logic [31:0] rd_val = '0;
    bit          busy_mode = 1'b0;
    int          cyc_n = 0;
    int          hi_cnt, first_hi, last_hi, ovr_cnt, tx_first, busy_left;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;
    logic [7:0]  txq[$];
    bit          prev_stb = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        hi_cnt  = 0;
        ovr_cnt = 0;
        txq.delete();
    endtask

    // Slave, transmitter-busy model and monitors share one loop so cycle numbers agree.
    initial begin
        busy_left = 0;
        clear_stats();
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_rty_i = 1'b0;
            wb_dat_i = 32'h0BAD0BAD;
            if (wb_cyc_o) begin
                if (hi_cnt == 0) begin
                    first_hi = cyc_n;
                    cap_adr  = wb_adr_o;
                    cap_dat  = wb_dat_o;
                    cap_we   = wb_we_o;
                    cap_sel  = wb_sel_o;
                end
                case (slv_mode)
                    SlvAck:    if (hi_cnt == ack_wait) begin wb_ack_i = 1'b1; wb_dat_i = rd_val; end
                    SlvErr:    if (hi_cnt == 0) wb_err_i = 1'b1;
                    SlvAckErr: if (hi_cnt == 0) begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
                    SlvRty:    if (hi_cnt == 2 || hi_cnt == 5) wb_rty_i = 1'b1;
                    default:   ;
                endcase
                hi_cnt++;
                last_hi = cyc_n;
            end
            if (ovr_o) ovr_cnt++;
            if (tx_stb_o) begin
                check_val("tx_vs_busy", {31'd0, tx_busy_i}, 32'd0);
                check_val("tx_back2back", {31'd0, prev_stb}, 32'd0);
                if (txq.size() == 0) tx_first = cyc_n;
                txq.push_back(tx_data_o);
                if (busy_mode) busy_left = 10;
            end
            prev_stb = tx_stb_o;
            if (busy_left > 0) begin
                tx_busy_i = 1'b1;
                busy_left--;
            end else begin
                tx_busy_i = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data_i = b;
        rx_stb_i  = 1'b1;
        @(posedge clk);
        #1;
        rx_stb_i  = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat);
        send_byte(op);
        for (int i = 3; i >= 0; i--) send_byte(adr[8*i+:8]);
        if (op == CMD_WR) for (int i = 3; i >= 0; i--) send_byte(dat[8*i+:8]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val({tag, "_done"}, {31'd0, busy_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_tx(input string tag, input int cnt, input logic [39:0] exp);
        check_val({tag, "_txn"}, txq.size(), cnt);
        for (int i = 0; i < cnt && i < txq.size(); i++)
            check_val({tag, "_tx"}, {24'd0, txq[i]}, {24'd0, exp[39-8*i -: 8]});
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cyc", {28'd0, wb_cyc_o, wb_stb_o, wb_we_o, busy_o}, 32'd0);
        check_val("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        check_val("rst_adr", wb_adr_o, 32'd0);
        check_val("rst_dat", wb_dat_o, 32'd0);
        check_val("rst_tx", {22'd0, tx_stb_o, ovr_o, tx_data_o}, 32'd0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        // Write, ack on the third bus clock
        clear_stats();
        slv_mode = SlvAck;
        ack_wait = 2;
        send_cmd(CMD_WR, 32'h0000F000, 32'h00000041);
        check_val("wr_latency", {31'd0, wb_cyc_o}, 32'd1);
        wait_idle("wr");
        check_val("wr_adr", cap_adr, 32'h0000F000);
        check_val("wr_dat", cap_dat, 32'h00000041);
        check_val("wr_we_sel", {27'd0, cap_we, cap_sel}, 32'h1F);
        check_val("wr_hi", hi_cnt, 3);
        check_val("wr_ovr", ovr_cnt, 0);
        check_tx("wr", 1, 40'h4B_00000000);
        check_val("wr_hold", wb_adr_o ^ wb_dat_o, 32'h0000F041);

        // Read with a slow transmitter
        clear_stats();
        busy_mode = 1'b1;
        ack_wait  = 0;
        rd_val    = 32'hDEADBEEF;
        send_cmd(CMD_RD, 32'h00000010, 32'h0);
        wait_idle("rd");
        check_val("rd_adr_we", {cap_adr[30:0], cap_we}, 32'h00000020);
        check_tx("rd", 5, 40'h4B_DEADBEEF);
        check_val("rd_resp_gap", {31'd0, tx_first >= last_hi + 2}, 32'd1);
        repeat (12) @(posedge clk);
        #1;
        busy_mode = 1'b0;

        // Error, then ack and err together
        clear_stats();
        slv_mode = SlvErr;
        send_cmd(CMD_RD, 32'h00000040, 32'h0);
        wait_idle("err");
        check_val("err_hi", hi_cnt, 1);
        check_tx("err", 1, 40'h45_00000000);
        clear_stats();
        slv_mode = SlvAckErr;
        send_cmd(CMD_RD, 32'h00000044, 32'h0);
        wait_idle("ackerr");
        check_val("ackerr_hi", hi_cnt, 1);
        check_tx("ackerr", 1, 40'h45_00000000);

        // Watchdog with no response, then with two retries
        clear_stats();
        slv_mode = SlvNone;
        send_cmd(CMD_RD, 32'h00000050, 32'h0);
        wait_idle("tmo");
        check_val("tmo_window", last_hi - first_hi + 1, 15);
        check_val("tmo_hi", hi_cnt, 15);
        check_tx("tmo", 1, 40'h45_00000000);
        clear_stats();
        slv_mode = SlvRty;
        send_cmd(CMD_WR, 32'h00000060, 32'h12);
        wait_idle("rty");
        check_val("rty_window", last_hi - first_hi + 1, 15);
        check_val("rty_hi", hi_cnt, 13);
        check_tx("rty", 1, 40'h45_00000000);

        // Stray byte while the bus cycle is open
        clear_stats();
        slv_mode = SlvAck;
        ack_wait = 4;
        send_cmd(CMD_WR, 32'h00000100, 32'h000000A5);
        send_byte(CMD_RD);
        wait_idle("ovr");
        check_val("ovr_cnt", ovr_cnt, 1);
        check_val("ovr_adr", cap_adr, 32'h00000100);
        check_tx("ovr", 1, 40'h4B_00000000);

        // Reset in the middle of a bus cycle
        clear_stats();
        slv_mode = SlvNone;
        send_cmd(CMD_RD, 32'h00000030, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid_rst_cyc", {30'd0, wb_cyc_o, busy_o}, 32'd0);
        check_val("mid_rst_adr", wb_adr_o, 32'd0);
        rst_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_val("mid_rst_tx", txq.size(), 0);
        clear_stats();
        slv_mode = SlvAck;
        ack_wait = 0;
        rd_val   = 32'h12345678;
        send_cmd(CMD_RD, 32'h00000020, 32'h0);
        wait_idle("post_rst");
        check_val("post_rst_adr", cap_adr, 32'h00000020);
        check_tx("post_rst", 5, 40'h4B_12345678);

        // Partial command followed by a long idle gap
        clear_stats();
        send_byte(CMD_WR);
        send_byte(8'h00);
        repeat (150) @(posedge clk);
        #1;
`ifdef WB_DBG_RX_TIMEOUT_EN
        check_val("idle_drop", {31'd0, busy_o}, 32'd0);
        rd_val = 32'hCAFEF00D;
        send_cmd(CMD_RD, 32'h00000010, 32'h0);
        wait_idle("idle_rd");
        check_val("idle_rd_adr_we", {cap_adr[30:0], cap_we}, 32'h00000020);
        check_tx("idle_rd", 5, 40'h4B_CAFEF00D);
`else
        check_val("idle_wait", {31'd0, busy_o}, 32'd1);
        check_val("idle_no_bus", hi_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
